// File: rtl/ofdm_ser_pkg.sv
// Shared types and helpers for the OFDM symbol serializer.
// Build option: OFDM_SER_TWOS_COMP_EN selects two's-complement output coding.
package ofdm_ser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CP   = 2'd1,
        DATA = 2'd2
    } ser_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned midscale(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Divides clk by CLK_DIV, giving a one-cycle sample tick and a registered
// sample clock that is low for the first half of each sample period.
module sample_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick,
    output logic o_clk
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_q, clk_d;

    // The tick marks the cycle whose closing edge wraps the counter to 0.
    always_comb begin
        o_tick = (cnt_q == LAST);
        cnt_d  = o_tick ? '0 : cnt_q + 1'b1;
        clk_d  = (cnt_d >= HALF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

    assign o_clk = clk_q;

endmodule

// File: rtl/ofdm_symbol_serializer.sv
// Double-buffered OFDM symbol serializer: cyclic prefix then N samples per symbol.
// Build option: OFDM_SER_TWOS_COMP_EN flips the MSB so midscale reads as zero.
module ofdm_symbol_serializer
    import ofdm_ser_pkg::*;
#(
    parameter int WIDTH   = 10,
    parameter int N       = 64,
    parameter int CP_MAX  = 16,
    parameter int CLK_DIV = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_enable,
    input  logic [N*WIDTH-1:0]             i_data,
    input  logic [$clog2(CP_MAX+1)-1:0]    i_cp_len,
    input  logic                           i_valid,
    output logic                           o_ready,
    output logic [WIDTH-1:0]               o_sample,
    output logic                           o_sample_valid,
    output logic                           o_sym_start,
    output logic                           o_underrun,
    output logic                           o_clk
);

    localparam int CPW = $clog2(CP_MAX + 1);
    localparam int IW  = idx_width(N);
    localparam logic [WIDTH-1:0] MID      = WIDTH'(midscale(WIDTH));
    localparam logic [CPW-1:0]   CP_CLAMP = CPW'(CP_MAX);
    localparam logic [IW-1:0]    LAST_IDX = IW'(N - 1);

    ser_state_e state_q, state_d;
    logic [IW-1:0] k_q, k_d;

    logic [N*WIDTH-1:0] stg_mem_q, stg_mem_d;
    logic [CPW-1:0]     stg_cp_q, stg_cp_d;
    logic               stg_full_q, stg_full_d;
    logic               ready_q, ready_d;

    logic [N*WIDTH-1:0] act_mem_q, act_mem_d;
    logic [CPW-1:0]     act_cp_q, act_cp_d;

    logic [WIDTH-1:0] sample_q, sample_d;
    logic             sample_valid_q, sample_valid_d;
    logic             sym_start_q, sym_start_d;
    logic             underrun_q, underrun_d;

    logic             tick;
    logic             load;
    logic             accept;
    logic [WIDTH-1:0] raw;

    function automatic logic [WIDTH-1:0] pick(input logic [N*WIDTH-1:0] mem,
                                              input logic [IW-1:0]      idx);
        return mem[int'(idx)*WIDTH +: WIDTH];
    endfunction

    sample_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .o_tick (tick),
        .o_clk  (o_clk)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            k_q            <= '0;
            stg_cp_q       <= '0;
            stg_full_q     <= 1'b0;
            ready_q        <= 1'b1;
            act_cp_q       <= '0;
            sample_q       <= MID;
            sample_valid_q <= 1'b0;
            sym_start_q    <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            stg_cp_q       <= stg_cp_d;
            stg_full_q     <= stg_full_d;
            ready_q        <= ready_d;
            act_cp_q       <= act_cp_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            sym_start_q    <= sym_start_d;
            underrun_q     <= underrun_d;
        end
    end

    // Sample storage carries no reset; the full flag alone says whether it is live.
    always_ff @(posedge clk) begin
        stg_mem_q <= stg_mem_d;
        act_mem_q <= act_mem_d;
    end

    // Leaving IDLE emits the first sample straight from staging, so k starts at 1.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        load    = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (i_enable && stg_full_q) begin
                        load = 1'b1;
                        if (stg_cp_q == CPW'(1)) begin
                            state_d = DATA;
                            k_d     = '0;
                        end else begin
                            state_d = (stg_cp_q == '0) ? DATA : CP;
                            k_d     = IW'(1);
                        end
                    end
                end
                CP: begin
                    if (k_q == IW'(act_cp_q) - 1'b1) begin
                        state_d = DATA;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                DATA: begin
                    if (k_q == LAST_IDX) begin
                        k_d = '0;
                        if (i_enable && stg_full_q) begin
                            load    = 1'b1;
                            state_d = (stg_cp_q == '0) ? DATA : CP;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Accept and transfer never coincide since ready is low whenever staging is full.
    always_comb begin
        accept     = i_valid && ready_q;
        stg_mem_d  = stg_mem_q;
        stg_cp_d   = stg_cp_q;
        stg_full_d = stg_full_q;
        act_mem_d  = act_mem_q;
        act_cp_d   = act_cp_q;
        if (accept) begin
            stg_mem_d  = i_data;
            stg_cp_d   = (i_cp_len > CP_CLAMP) ? CP_CLAMP : i_cp_len;
            stg_full_d = 1'b1;
        end
        if (load) begin
            act_mem_d  = stg_mem_q;
            act_cp_d   = stg_cp_q;
            stg_full_d = 1'b0;
        end
        ready_d = !stg_full_d;
    end

    // CP sample k sits at index N-cp+k, which is k-cp modulo the power-of-two N.
    always_comb begin
        raw         = MID;
        sym_start_d = 1'b0;
        underrun_d  = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        raw         = pick(stg_mem_q, IW'(0) - IW'(stg_cp_q));
                        sym_start_d = 1'b1;
                    end
                end
                CP: begin
                    raw         = pick(act_mem_q, k_q - IW'(act_cp_q));
                    sym_start_d = (k_q == '0);
                end
                DATA: begin
                    raw         = pick(act_mem_q, k_q);
                    sym_start_d = (k_q == '0) && (act_cp_q == '0);
                    underrun_d  = (k_q == LAST_IDX) && i_enable && !stg_full_q;
                end
                default: raw = MID;
            endcase
        end
        sample_valid_d = tick;
`ifdef OFDM_SER_TWOS_COMP_EN
        sample_d = tick ? (raw ^ MID) : sample_q;
`else
        sample_d = tick ? raw : sample_q;
`endif
    end

    assign o_ready        = ready_q;
    assign o_sample       = sample_q;
    assign o_sample_valid = sample_valid_q;
    assign o_sym_start    = sym_start_q;
    assign o_underrun     = underrun_q;

endmodule

// File: tb/tb_ofdm_symbol_serializer.sv
// Self-checking bench for ofdm_symbol_serializer: table vectors, corner sequences
// and randomized traffic against a queue-based reference of the output stream.
module tb_ofdm_symbol_serializer;

    localparam int WIDTH   = 10;
    localparam int N       = 64;
    localparam int CP_MAX  = 16;
    localparam int CLK_DIV = 2;
    localparam int CPW     = $clog2(CP_MAX + 1);
    localparam int MID_RAW = 1 << (WIDTH - 1);
    localparam int LIMIT   = 4 * (CP_MAX + N) * CLK_DIV + 20;

    typedef int iq_t[$];

    typedef struct {
        int cp_in;
        int exp_first;
        int exp_count;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 i_enable = 1'b0;
    logic                 i_valid = 1'b0;
    logic [N*WIDTH-1:0]   i_data = '0;
    logic [CPW-1:0]       i_cp_len = '0;
    logic                 o_ready;
    logic [WIDTH-1:0]     o_sample;
    logic                 o_sample_valid;
    logic                 o_sym_start;
    logic                 o_underrun;
    logic                 o_clk;

    int n_checks = 0;
    int n_pass   = 0;

    ofdm_symbol_serializer #(
        .WIDTH   (WIDTH),
        .N       (N),
        .CP_MAX  (CP_MAX),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_enable       (i_enable),
        .i_data         (i_data),
        .i_cp_len       (i_cp_len),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .o_sample       (o_sample),
        .o_sample_valid (o_sample_valid),
        .o_sym_start    (o_sym_start),
        .o_underrun     (o_underrun),
        .o_clk          (o_clk)
    );

    always #5 clk = ~clk;

    function automatic int to_out(input int raw);
`ifdef OFDM_SER_TWOS_COMP_EN
        return (raw ^ MID_RAW) & ((1 << WIDTH) - 1);
`else
        return raw & ((1 << WIDTH) - 1);
`endif
    endfunction

    // A symbol as it should appear on the wire: clamped CP tail, then all N samples.
    function automatic iq_t expand(input logic [N*WIDTH-1:0] d, input int cp);
        iq_t q;
        int  c;
        c = (cp > CP_MAX) ? CP_MAX : cp;
        for (int k = 0; k < c; k++) q.push_back(int'(d[(N - c + k)*WIDTH +: WIDTH]));
        for (int k = 0; k < N; k++) q.push_back(int'(d[k*WIDTH +: WIDTH]));
        return q;
    endfunction

    function automatic logic [N*WIDTH-1:0] ramp_sym();
        logic [N*WIDTH-1:0] d;
        for (int k = 0; k < N; k++) d[k*WIDTH +: WIDTH] = WIDTH'(k);
        return d;
    endfunction

    function automatic logic [N*WIDTH-1:0] fill_sym(input int v);
        logic [N*WIDTH-1:0] d;
        for (int k = 0; k < N; k++) d[k*WIDTH +: WIDTH] = WIDTH'(v);
        return d;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    // Reference model: the output stream is a queue of samples still to play,
    // plus one pending expanded symbol standing in for the staging buffer.
    int  m_phase;
    iq_t m_play;
    iq_t m_pend;
    bit  m_pend_full, m_first, m_ready, m_live = 1'b0, m_tick;
    int  exp_raw;
    bit  exp_valid, exp_start, exp_under, exp_clk;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_play.delete();
            m_pend.delete();
            m_pend_full = 1'b0;
            m_first = 1'b0;
            m_ready = 1'b1;
            exp_raw = MID_RAW;
            exp_valid = 1'b0;
            exp_start = 1'b0;
            exp_under = 1'b0;
            exp_clk = 1'b0;
            m_live = 1'b1;
        end else begin
            m_tick = (m_phase == CLK_DIV - 1);
            exp_valid = m_tick;
            exp_start = 1'b0;
            exp_under = 1'b0;
            if (m_tick) begin
                if (m_play.size() == 0 && i_enable && m_pend_full) begin
                    m_play = m_pend;
                    m_pend_full = 1'b0;
                    m_first = 1'b1;
                end
                if (m_play.size() > 0) begin
                    exp_raw = m_play.pop_front();
                    exp_start = m_first;
                    m_first = 1'b0;
                    if (m_play.size() == 0) begin
                        if (i_enable && m_pend_full) begin
                            m_play = m_pend;
                            m_pend_full = 1'b0;
                            m_first = 1'b1;
                        end else if (i_enable) begin
                            exp_under = 1'b1;
                        end
                    end
                end else begin
                    exp_raw = MID_RAW;
                end
            end
            if (i_valid && m_ready) begin
                m_pend = expand(i_data, int'(i_cp_len));
                m_pend_full = 1'b1;
            end
            m_ready = !m_pend_full;
            m_phase = m_tick ? 0 : m_phase + 1;
            exp_clk = (m_phase >= CLK_DIV / 2);
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            checkOutput("o_sample", int'(o_sample), to_out(exp_raw));
            checkOutput("o_sample_valid", int'(o_sample_valid), int'(exp_valid));
            checkOutput("o_sym_start", int'(o_sym_start), int'(exp_start));
            checkOutput("o_underrun", int'(o_underrun), int'(exp_under));
            checkOutput("o_ready", int'(o_ready), int'(m_ready));
            checkOutput("o_clk", int'(o_clk), int'(exp_clk));
        end
    end

    // Stream statistics sampled just after each active edge.
    int mon_samples, mon_starts, mon_unders, mon_nonmid, mon_last, mon_a;
    int mon_first_idx, mon_first_val, mon_under_idx;

    task automatic clear_mon();
        mon_samples = 0; mon_starts = 0; mon_unders = 0; mon_nonmid = 0;
        mon_last = -1; mon_a = 0; mon_first_idx = -1; mon_first_val = -1; mon_under_idx = -1;
    endtask

    always @(posedge clk) begin
        #1;
        if (o_sample_valid === 1'b1) begin
            mon_samples++;
            if (o_sym_start) begin
                if (mon_starts == 0) begin
                    mon_first_idx = mon_samples;
                    mon_first_val = int'(o_sample);
                end
                mon_starts++;
            end
            if (o_underrun) begin
                if (mon_unders == 0) mon_under_idx = mon_samples;
                mon_unders++;
            end
            if (int'(o_sample) != to_out(MID_RAW)) begin
                mon_nonmid++;
                mon_last = int'(o_sample);
            end
            if (int'(o_sample) == to_out(32'h100)) mon_a++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        i_valid = 1'b0;
        i_enable = 1'b0;
        repeat (3) @(negedge clk);
        clear_mon();
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input logic [N*WIDTH-1:0] d, input int cp);
        int waited;
        waited = 0;
        i_data = d;
        i_cp_len = CPW'(cp);
        i_valid = 1'b1;
        while (!o_ready && waited < LIMIT) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("accept_wait", int'(o_ready), 1);
        if (o_ready) begin
            @(posedge clk);
            @(negedge clk);
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_underrun();
        int cyc;
        cyc = 0;
        while (mon_unders == 0 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("underrun_seen", int'(mon_unders > 0), 1);
    endtask

    task automatic wait_nonmid(input int target);
        int cyc;
        cyc = 0;
        while (mon_nonmid < target && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("nonmid_reached", int'(mon_nonmid >= target), 1);
    endtask

    initial begin
        vec_t vecs[5];
        logic [N*WIDTH-1:0] rd;
        int gap;

        vecs[0] = '{cp_in: 16, exp_first: 48, exp_count: 80};
        vecs[1] = '{cp_in: 0,  exp_first: 0,  exp_count: 64};
        vecs[2] = '{cp_in: 31, exp_first: 48, exp_count: 80};
        vecs[3] = '{cp_in: 1,  exp_first: 63, exp_count: 65};
        vecs[4] = '{cp_in: 7,  exp_first: 57, exp_count: 71};

        do_reset();
        checkOutput("rst_ready", int'(o_ready), 1);
        checkOutput("rst_sample", int'(o_sample), to_out(MID_RAW));
        checkOutput("rst_valid", int'(o_sample_valid), 0);
        checkOutput("rst_start", int'(o_sym_start), 0);
        checkOutput("rst_underrun", int'(o_underrun), 0);
        checkOutput("rst_clk", int'(o_clk), 0);

        $display("[TB] table vectors");
        for (int i = 0; i < 5; i++) begin
            do_reset();
            i_enable = 1'b1;
            applyStimulus(ramp_sym(), vecs[i].cp_in);
            wait_underrun();
            checkOutput("vec_first", mon_first_val, to_out(vecs[i].exp_first));
            checkOutput("vec_count", mon_under_idx - mon_first_idx + 1, vecs[i].exp_count);
            checkOutput("vec_starts", mon_starts, 1);
        end

        $display("[TB] back-to-back symbols");
        do_reset();
        i_enable = 1'b1;
        applyStimulus(fill_sym(32'h100), 16);
        applyStimulus(fill_sym(32'h200), 16);
        checkOutput("ready_low_after_b", int'(o_ready), 0);
        wait_underrun();
        checkOutput("b2b_span", mon_under_idx - mon_first_idx + 1, 160);
        checkOutput("b2b_a_count", mon_a, 80);
        checkOutput("b2b_starts", mon_starts, 2);
        repeat (4 * CLK_DIV) @(negedge clk);
        checkOutput("b2b_underruns", mon_unders, 1);
        checkOutput("idle_sample", int'(o_sample), to_out(MID_RAW));

        $display("[TB] reset mid-symbol");
        do_reset();
        i_enable = 1'b1;
        applyStimulus(ramp_sym(), 16);
        applyStimulus(fill_sym(32'h155), 16);
        wait_nonmid(16 + 31);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("mid_rst_ready", int'(o_ready), 1);
        checkOutput("mid_rst_sample", int'(o_sample), to_out(MID_RAW));
        checkOutput("mid_rst_valid", int'(o_sample_valid), 0);
        clear_mon();
        repeat (40) @(negedge clk);
        checkOutput("mid_rst_starts", mon_starts, 0);
        checkOutput("mid_rst_nonmid", mon_nonmid, 0);

        $display("[TB] enable dropped mid-symbol");
        do_reset();
        i_enable = 1'b1;
        applyStimulus(ramp_sym(), 4);
        wait_nonmid(4 + 11);
        i_enable = 1'b0;
        wait_nonmid(68);
        repeat (20) @(negedge clk);
        checkOutput("drop_count", mon_nonmid, 68);
        checkOutput("drop_last", mon_last, to_out(63));
        checkOutput("drop_underrun", mon_unders, 0);

        $display("[TB] randomized traffic");
        do_reset();
        for (int s = 0; s < 40; s++) begin
            for (int k = 0; k < N; k++) rd[k*WIDTH +: WIDTH] = WIDTH'($urandom);
            i_enable = 1'b1;
            applyStimulus(rd, int'($urandom_range(0, 31)));
            gap = int'($urandom_range(0, 200));
            if ($urandom_range(0, 3) == 0) i_enable = 1'b0;
            repeat (gap) @(negedge clk);
        end
        i_enable = 1'b1;
        repeat (400) @(negedge clk);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
